pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 141 ++++++++++++++
 tb/tb_pwm_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. All channels share one counter and active period,
// so their periods are phase-aligned. Define PWM_SHADOW_EN for double-buffered duty updates.
module pwm_multi #(
  parameter int               WIDTH      = 10,
  parameter int               CH         = 4,
  parameter logic [WIDTH-1:0] PERIOD_RST = {WIDTH{1'b1}},
  localparam int              IDX_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic             wr,
  input  logic [IDX_W-1:0] wr_ch,
  input  logic [WIDTH-1:0] wr_duty,
  output logic [CH-1:0]    pwm_out,
  output logic             period_start
);

  // Write interface: wr is a strobe with no ready; every cycle with wr high is
  // one write of wr_duty to channel wr_ch. Indices >= CH match no channel and are dropped.

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_act;
  logic             en_prev;

  logic [WIDTH-1:0] duty_act [CH];
  logic [WIDTH-1:0] cmp_duty [CH];
  logic [CH-1:0]    wr_hit;

  logic             en_rise;
  logic             wrap;
  logic             reload;
  logic [WIDTH-1:0] period_eff;

  assign en_rise = en && !en_prev;
  assign wrap    = (cnt == period_act);
  assign reload  = en_rise || wrap;

  // On the enable-rise edge the new period is already the one governing the count.
  assign period_eff = en_rise ? period : period_act;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CH; i++) begin
      wr_hit[i] = wr && (wr_ch == IDX_W'(i));
    end
  end

  // Shared counter, period register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period_act   <= PERIOD_RST;
      en_prev      <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      en_prev <= en;
      if (en) begin
        if (reload) begin
          period_act <= period;
        end
        if (cnt == period_eff) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
        period_start <= (cnt == '0);
        for (int i = 0; i < CH; i++) begin
          pwm_out[i] <= (cnt < cmp_duty[i]);
        end
      end else begin
        cnt          <= '0;
        period_start <= 1'b0;
        pwm_out      <= '0;
      end
    end
  end

`ifdef PWM_SHADOW_EN

  logic [WIDTH-1:0] duty_pend [CH];
  logic [WIDTH-1:0] duty_next [CH];

  // A write landing on a transfer edge is forwarded straight into that transfer.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      duty_next[i] = wr_hit[i] ? wr_duty : duty_pend[i];
    end
  end

  // The enable-rise edge compares cnt=0 against the duty being transferred in.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cmp_duty[i] = en_rise ? duty_next[i] : duty_act[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        duty_pend[i] <= '0;
        duty_act[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        duty_pend[i] <= duty_next[i];
        if (en && reload) begin
          duty_act[i] <= duty_next[i];
        end
      end
    end
  end

`else

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cmp_duty[i] = duty_act[i];
    end
  end

  // Direct update: the new duty joins the compare on the following cycle, even mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        duty_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_hit[i]) begin
          duty_act[i] <= wr_duty;
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: table of single-channel waveforms plus hand-written
// sequences for duty/period updates, enable gaps, async reset and invalid channel writes.
module tb_pwm_multi;

  localparam int WIDTH = 10;
  localparam int CH    = 6;
  localparam int IDX_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             en;
  logic [WIDTH-1:0] period;
  logic             wr;
  logic [IDX_W-1:0] wr_ch;
  logic [WIDTH-1:0] wr_duty;
  logic [CH-1:0]    pwm_out;
  logic             period_start;

  pwm_multi #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .period       (period),
    .wr           (wr),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {period_start, pwm_out} expected at one sample (negedge after an edge).
  logic [CH:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push_exp(input int ch, input logic pwm_bit, input logic ps_bit);
    logic [CH:0] e;
    e = '0;
    e[ch] = pwm_bit;
    e[CH] = ps_bit;
    exp_q.push_back(e);
  endtask

  // One period of length plen with 'high' leading high cycles on channel ch.
  task automatic push_period(input int ch, input int plen, input int high);
    for (int k = 0; k < plen; k++) begin
      push_exp(ch, (k < high), (k == 0));
    end
  endtask

  task automatic compare(input string name, input logic [CH:0] exp_v);
    logic [CH:0] act;
    act = {period_start, pwm_out};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @%0t: got ps=%0b pwm=%b, want ps=%0b pwm=%b",
               name, $time, act[CH], act[CH-1:0], exp_v[CH], exp_v[CH-1:0]);
    end
  endtask

  task automatic check_next(input string name);
    logic [CH:0] exp_v;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    compare(name, exp_v);
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) check_next(name);
  endtask

  // ---------------- drivers (called at a negedge) ----------------
  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    wr = 1'b0;
    #2 rst = 1'b1;
    #1 compare("rst_state", '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_cmd(input logic [IDX_W-1:0] ch, input logic [WIDTH-1:0] d);
    wr      = 1'b1;
    wr_ch   = ch;
    wr_duty = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string            name;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic [IDX_W-1:0] ch;
    int               plen;  // cycles per period
    int               high;  // expected high cycles per period
    int               nper;  // periods to observe
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"p9_d3",    10'd9, 10'd3,  3'd0, 10, 3,  2};
    tbl[1] = '{"p9_d0",    10'd9, 10'd0,  3'd1, 10, 0,  2};
    tbl[2] = '{"p9_d15",   10'd9, 10'd15, 3'd2, 10, 10, 3};
    tbl[3] = '{"p4_d2",    10'd4, 10'd2,  3'd3, 5,  2,  4};
    tbl[4] = '{"p9_d10",   10'd9, 10'd10, 3'd4, 10, 10, 2};
    tbl[5] = '{"p9_d9",    10'd9, 10'd9,  3'd5, 10, 9,  2};
    tbl[6] = '{"p0_d1",    10'd0, 10'd1,  3'd0, 1,  1,  5};
    tbl[7] = '{"p1_d1",    10'd1, 10'd1,  3'd1, 2,  1,  5};
    tbl[8] = '{"p2_d3",    10'd2, 10'd3,  3'd3, 3,  3,  4};

    rst = 1'b1; en = 1'b0; wr = 1'b0; wr_ch = '0; wr_duty = '0; period = 10'd9;
    #1 compare("reset_init", '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven steady-state waveforms.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      period = tbl[v].period;
      wr_cmd(tbl[v].ch, tbl[v].duty);
      en = 1'b1;
      for (int p = 0; p < tbl[v].nper; p++) begin
        push_period(int'(tbl[v].ch), tbl[v].plen, tbl[v].high);
      end
      drain(tbl[v].name);
    end

    // Duty 3->7 written at cnt=5, then 7->2 written on the wrap edge (cnt=9).
    do_reset();
    period = 10'd9;
    wr_cmd(3'd0, 10'd3);
    en = 1'b1;
`ifdef PWM_SHADOW_EN
    push_period(0, 10, 3);
`else
    for (int k = 0; k < 10; k++) push_exp(0, (k < 3) || (k == 6), (k == 0));
`endif
    push_period(0, 10, 7);
    push_period(0, 10, 2);
    push_period(0, 10, 2);
    for (int k = 0; k < 40; k++) begin
      if (k == 5)  begin wr = 1'b1; wr_ch = 3'd0; wr_duty = 10'd7; end
      if (k == 19) begin wr = 1'b1; wr_ch = 3'd0; wr_duty = 10'd2; end
      check_next("duty_update");
      wr = 1'b0;
    end

    // Period 9->4 requested at cnt=2: current period stays 10 cycles.
    do_reset();
    period = 10'd9;
    wr_cmd(3'd0, 10'd3);
    en = 1'b1;
    push_period(0, 10, 3);
    for (int p = 0; p < 3; p++) push_period(0, 5, 3);
    for (int k = 0; k < 25; k++) begin
      if (k == 2) period = 10'd4;
      check_next("period_change");
    end

    // Enable gap: outputs drop, a write during the gap applies, restart from cnt=0.
    do_reset();
    period = 10'd9;
    wr_cmd(3'd0, 10'd3);
    en = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(0, (k < 3), (k == 0));
    for (int k = 0; k < 3; k++) push_exp(0, 1'b0, 1'b0);
    push_period(0, 10, 5);
    for (int k = 0; k < 18; k++) begin
      if (k == 5) en = 1'b0;
      if (k == 6) begin wr = 1'b1; wr_ch = 3'd0; wr_duty = 10'd5; end
      if (k == 8) en = 1'b1;
      check_next("en_gap");
      wr = 1'b0;
    end

    // Asynchronous reset while pwm_out[0] is high, then restart with duties cleared.
    do_reset();
    period = 10'd9;
    wr_cmd(3'd0, 10'd3);
    en = 1'b1;
    push_exp(0, 1'b1, 1'b1);
    push_exp(0, 1'b1, 1'b0);
    drain("pre_rst");
    #2 rst = 1'b1;
    #1 compare("rst_mid_period", '0);
    @(negedge clk);
    rst = 1'b0;
    push_period(0, 10, 0);
    push_period(0, 10, 0);
    drain("rst_resume");

    // Writes to nonexistent channels 7 and 6 must not disturb anything.
    do_reset();
    period = 10'd9;
    wr_cmd(3'd7, 10'd8);
    wr_cmd(3'd6, 10'd4);
    wr_cmd(3'd0, 10'd3);
    en = 1'b1;
    push_period(0, 10, 3);
    push_period(0, 10, 3);
    drain("bad_channel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
